store_drain_buffer: RTL

Write-coalescing buffer between the store queue and the dcache store port. It accepts up to two committed stores per cycle from the store queue and merges stores that hit the same 8-byte doubleword. It drains entries in FIFO order to the dcache through a valid/ready handshake, and answers same-cycle load forwarding queries for committed-but-not-yet-written data.

---
 rtl/store_drain_buffer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/store_drain_buffer.sv
// Write-coalescing store drain buffer: merges committed stores per doubleword,
// drains them in FIFO order to the dcache and forwards pending bytes to loads.
`ifndef PALEN
`define PALEN 40
`endif
`ifndef LDU_NUM
`define LDU_NUM 2
`endif

module store_drain_buffer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned HIGH_WATER = 6,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req_vld   [2],
    output logic                         o_req_rdy,
    input  logic [`PALEN-1:0]            i_req_paddr [2],
    input  logic [7:0]                   i_req_mask  [2],
    input  logic [63:0]                  i_req_data  [2],
    input  logic                         i_drain,
    output logic                         o_dc_vld,
    input  logic                         i_dc_rdy,
    output logic [`PALEN-1:0]            o_dc_paddr,
    output logic [7:0]                   o_dc_mask,
    output logic [63:0]                  o_dc_data,
    input  logic [`PALEN-1:0]            i_fwd_paddr [`LDU_NUM],
    output logic [7:0]                   o_fwd_mask  [`LDU_NUM],
    output logic [63:0]                  o_fwd_data  [`LDU_NUM],
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDL_W = $clog2(TIMEOUT + 1);
    localparam int unsigned DW_W  = `PALEN - 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    function automatic logic [63:0] expand(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b*8 +: 8] = {8{m[b]}};
        end
        return r;
    endfunction

    logic              ent_vld  [DEPTH];
    logic              ent_lck  [DEPTH];
    logic [DW_W-1:0]   ent_dw   [DEPTH];
    logic [7:0]        ent_mask [DEPTH];
    logic [63:0]       ent_data [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [IDL_W-1:0]  idle_cnt;
    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic              load;
    logic              deq;
    logic              drain_start;

    logic              acc      [2];
    logic [DW_W-1:0]   dw       [2];
    logic              hit      [2];
    logic [PTR_W-1:0]  hit_idx  [2];
    logic              same;
    logic              wr_en    [2];
    logic              wr_alloc [2];
    logic [PTR_W-1:0]  wr_idx   [2];
    logic [7:0]        wr_mask  [2];
    logic [63:0]       wr_data  [2];
    logic [CNT_W-1:0]  n_alloc;
    logic              unused_addr_bits;

    assign o_req_rdy   = !rst && (count <= CNT_W'(DEPTH - 2));
    assign o_count     = count;
    assign o_empty     = (count == '0);
    assign deq         = (state == ST_SEND) && i_dc_rdy;
    assign drain_start = (count != '0) &&
                         ((count >= CNT_W'(HIGH_WATER)) || i_drain ||
                          (idle_cnt >= IDL_W'(TIMEOUT)));

    // Drain FSM next-state
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (drain_start) begin
                    state_nxt = ST_SEND;
                    load      = 1'b1;
                end
            end
            ST_SEND: begin
                if (i_dc_rdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Merge lookup; the head being locked this cycle is already off limits
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            acc[p]     = i_req_vld[p] && o_req_rdy;
            dw[p]      = i_req_paddr[p][`PALEN-1:3];
            hit[p]     = 1'b0;
            hit_idx[p] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (ent_vld[i] && !ent_lck[i] && !(load && (PTR_W'(i) == head)) &&
                    (ent_dw[i] == dw[p])) begin
                    hit[p]     = 1'b1;
                    hit_idx[p] = PTR_W'(i);
                end
            end
        end
    end

    // Write slot selection; same-doubleword pairs fold into slot 0, port 1 bytes winning
    always_comb begin
        same        = acc[0] && acc[1] && (dw[0] == dw[1]);
        wr_en[0]    = acc[0];
        wr_en[1]    = acc[1] && !same;
        wr_mask[0]  = same ? (i_req_mask[0] | i_req_mask[1]) : i_req_mask[0];
        wr_data[0]  = same ? ((i_req_data[1] & expand(i_req_mask[1])) |
                              (i_req_data[0] & ~expand(i_req_mask[1])))
                           : i_req_data[0];
        wr_mask[1]  = i_req_mask[1];
        wr_data[1]  = i_req_data[1];
        wr_alloc[0] = wr_en[0] && !hit[0];
        wr_alloc[1] = wr_en[1] && !hit[1];
        wr_idx[0]   = hit[0] ? hit_idx[0] : tail;
        wr_idx[1]   = hit[1] ? hit_idx[1] : tail + PTR_W'(wr_alloc[0]);
        n_alloc     = CNT_W'(wr_alloc[0]) + CNT_W'(wr_alloc[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Entry array update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_vld[i]  <= 1'b0;
                ent_lck[i]  <= 1'b0;
                ent_dw[i]   <= '0;
                ent_mask[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (load) begin
                ent_lck[head] <= 1'b1;
            end
            if (deq) begin
                ent_vld[head] <= 1'b0;
                ent_lck[head] <= 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p]) begin
                    ent_vld[wr_idx[p]] <= 1'b1;
                    if (wr_alloc[p]) begin
                        ent_lck[wr_idx[p]]  <= 1'b0;
                        ent_dw[wr_idx[p]]   <= dw[p];
                        ent_mask[wr_idx[p]] <= wr_mask[p];
                        ent_data[wr_idx[p]] <= wr_data[p] & expand(wr_mask[p]);
                    end else begin
                        ent_mask[wr_idx[p]] <= ent_mask[wr_idx[p]] | wr_mask[p];
                        ent_data[wr_idx[p]] <= (ent_data[wr_idx[p]] & ~expand(wr_mask[p])) |
                                               (wr_data[p] & expand(wr_mask[p]));
                    end
                end
            end
        end
    end

    // Pointers, occupancy and idle timer
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            idle_cnt <= '0;
        end else begin
            head  <= head + PTR_W'(deq);
            tail  <= tail + PTR_W'(n_alloc);
            count <= count + n_alloc - CNT_W'(deq);
            if (acc[0] || acc[1] || (count == '0)) begin
                idle_cnt <= '0;
            end else if (idle_cnt < IDL_W'(TIMEOUT)) begin
                idle_cnt <= idle_cnt + IDL_W'(1);
            end
        end
    end

    // Dcache request registers, held stable through SEND
    always_ff @(posedge clk) begin
        if (rst) begin
            o_dc_vld   <= 1'b0;
            o_dc_paddr <= '0;
            o_dc_mask  <= '0;
            o_dc_data  <= '0;
        end else if (load) begin
            o_dc_vld   <= 1'b1;
            o_dc_paddr <= {ent_dw[head], 3'b000};
            o_dc_mask  <= ent_mask[head];
            o_dc_data  <= ent_data[head];
        end else if (deq) begin
            o_dc_vld   <= 1'b0;
        end
    end

    // Load forwarding: unlocked entry bytes override the locked head
    always_comb begin
        for (int l = 0; l < `LDU_NUM; l++) begin : fwd_lane
            logic [7:0]  lm;
            logic [7:0]  um;
            logic [63:0] ld;
            logic [63:0] ud;
            lm = '0;
            um = '0;
            ld = '0;
            ud = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[i] && (ent_dw[i] == i_fwd_paddr[l][`PALEN-1:3])) begin
                    if (ent_lck[i]) begin
                        lm = ent_mask[i];
                        ld = ent_data[i];
                    end else begin
                        um = ent_mask[i];
                        ud = ent_data[i];
                    end
                end
            end
            o_fwd_mask[l] = lm | um;
            o_fwd_data[l] = (ud & expand(um)) | (ld & expand(lm) & ~expand(um));
        end
    end

    always_comb begin
        unused_addr_bits = ^{i_req_paddr[0][2:0], i_req_paddr[1][2:0]};
        for (int l = 0; l < `LDU_NUM; l++) begin
            unused_addr_bits = unused_addr_bits ^ (^i_fwd_paddr[l][2:0]);
        end
    end

endmodule
